// File: rtl/adc_scan_avg.sv
// SPI scanner for an AD7324-style ADC: round-robin channel addressing, frame
// validation, two's-complement to offset-binary conversion and optional averaging.
module adc_scan_avg #(
    parameter int          N_CH      = 4,
    parameter int          M         = 12,
    parameter int          CLK_DIV   = 2,
    parameter int          QUIET_CYC = 4,
    parameter int          AVG_LOG2  = 0,
    parameter logic [15:0] CTRL_BASE = 16'h8010
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              DOUT,
    output logic              CS_N,
    output logic              SCLK,
    output logic              DIN,
    output logic [N_CH*M-1:0] CH_DATA,
    output logic [N_CH-1:0]   CH_VALID,
    output logic              FRAME_ERR,
    output logic              BUSY
);
    localparam int TMR_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] DIV_END   = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] QUIET_END = TMR_W'(QUIET_CYC - 1);
    localparam int ACC_W  = 13 + AVG_LOG2;
    localparam int SCNT_W = AVG_LOG2 + 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((1 << AVG_LOG2) - 1);
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [1:0] CH_LAST = 2'(N_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_QUIET} state_t;

    state_t              state_q;
    logic [TMR_W-1:0]    tmr_q;
    logic [4:0]          rise_q;
    logic [15:0]         sh_q;
    logic [1:0]          ptr_q, last_q, exp_q;
    logic                prime_q;
    logic                cs_n_q, sclk_q, din_q, err_q;
    logic [N_CH*M-1:0]   data_q;
    logic [N_CH-1:0]     vld_q;
    logic [ACC_W-1:0]    acc_q  [N_CH];
    logic [SCNT_W-1:0]   scnt_q [N_CH];

    logic [15:0]         ctrl_w;
    logic [3:0]          din_idx;
    logic [1:0]          id;
    logic                id_ok;
    logic [IDX_W-1:0]    sel;
    logic [12:0]         off13;
    logic [ACC_W-1:0]    sum;
    logic [M-1:0]        res;

    always_comb begin
        ctrl_w        = CTRL_BASE;
        ctrl_w[11:10] = ptr_q;
    end

    assign din_idx = 4'd14 - rise_q[3:0];
    assign id      = sh_q[14:13];
    assign id_ok   = !sh_q[15] && (id == exp_q) && (int'(id) < N_CH);
    assign sel     = id_ok ? IDX_W'(id) : '0;
    assign off13   = {~sh_q[12], sh_q[11:0]};
    assign sum     = acc_q[sel] + ACC_W'(off13);
    // Top M bits of (sum >> AVG_LOG2) as a 13-bit value; sum never overflows ACC_W.
    assign res     = sum[ACC_W-1 -: M];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            rise_q  <= '0;
            sh_q    <= '0;
            ptr_q   <= '0;
            last_q  <= '0;
            exp_q   <= '0;
            prime_q <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            din_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            vld_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                acc_q[i]  <= '0;
                scnt_q[i] <= '0;
            end
        end else begin
            vld_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ptr_q   <= '0;
                    last_q  <= '0;
                    prime_q <= 1'b1;
                    for (int i = 0; i < N_CH; i++) begin
                        acc_q[i]  <= '0;
                        scnt_q[i] <= '0;
                    end
                    if (EN) begin
                        state_q <= S_SETUP;
                        tmr_q   <= '0;
                        cs_n_q  <= 1'b0;
                        din_q   <= CTRL_BASE[15];
                    end
                end
                S_SETUP: begin
                    if (tmr_q == DIV_END) begin
                        // Leaving SETUP is the first SCLK fall.
                        tmr_q   <= '0;
                        rise_q  <= '0;
                        sclk_q  <= 1'b0;
                        sh_q    <= {sh_q[14:0], DOUT};
                        state_q <= S_SHIFT;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (tmr_q != DIV_END) begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end else begin
                        tmr_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rise_q <= rise_q + 5'd1;
                            din_q  <= (rise_q == 5'd15) ? 1'b0 : ctrl_w[din_idx];
                        end else if (rise_q == 5'd16) begin
                            state_q <= S_QUIET;
                            cs_n_q  <= 1'b1;
                            exp_q   <= last_q;
                            last_q  <= ptr_q;
                            ptr_q   <= (ptr_q == CH_LAST) ? 2'd0 : ptr_q + 2'd1;
                        end else begin
                            sclk_q <= 1'b0;
                            sh_q   <= {sh_q[14:0], DOUT};
                        end
                    end
                end
                S_QUIET: begin
                    if (tmr_q == '0) begin
                        if (prime_q) begin
                            prime_q <= 1'b0;
                        end else if (!id_ok) begin
                            err_q <= 1'b1;
                        end else if (scnt_q[sel] == SCNT_LAST) begin
                            data_q[int'(sel)*M +: M] <= res;
                            vld_q[sel]  <= 1'b1;
                            acc_q[sel]  <= '0;
                            scnt_q[sel] <= '0;
                        end else begin
                            acc_q[sel]  <= sum;
                            scnt_q[sel] <= scnt_q[sel] + SCNT_W'(1);
                        end
                    end
                    if (tmr_q == QUIET_END) begin
                        tmr_q <= '0;
                        if (EN) begin
                            state_q <= S_SETUP;
                            cs_n_q  <= 1'b0;
                            din_q   <= ctrl_w[15];
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign CS_N      = cs_n_q;
    assign SCLK      = sclk_q;
    assign DIN       = din_q;
    assign CH_DATA   = data_q;
    assign CH_VALID  = vld_q;
    assign FRAME_ERR = err_q;
    assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_scan_avg.sv
// Directed bench for adc_scan_avg: default instance plus a single-channel
// instance with 4-sample averaging, each driven by a simple ADC frame model.
module tb_adc_scan_avg;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        EN = 1'b0;
    logic        DOUT, CS_N, SCLK, DIN, FRAME_ERR, BUSY;
    logic [47:0] CH_DATA;
    logic [3:0]  CH_VALID;

    logic        en_a = 1'b0;
    logic        dout_a, cs_a, sclk_a, din_a, err_a, busy_a;
    logic [11:0] data_a;
    logic [0:0]  vld_a;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_start = 0;
    int t_prev = 0;
    int bi = 0;
    int bi_a = 0;
    logic [15:0] fw = 16'h0;
    logic [15:0] fw_a = 16'h0;
    logic [15:0] dw = 16'h0;

    adc_scan_avg dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN), .DOUT(DOUT),
        .CS_N(CS_N), .SCLK(SCLK), .DIN(DIN),
        .CH_DATA(CH_DATA), .CH_VALID(CH_VALID), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
    );

    adc_scan_avg #(.N_CH(1), .AVG_LOG2(2)) dut_avg (
        .CLK(CLK), .RSTn(RSTn), .EN(en_a), .DOUT(dout_a),
        .CS_N(cs_a), .SCLK(sclk_a), .DIN(din_a),
        .CH_DATA(data_a), .CH_VALID(vld_a), .FRAME_ERR(err_a), .BUSY(busy_a)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // ADC model: frame MSB presented at CS_N fall, next bit after each SCLK fall.
    assign DOUT   = (bi < 16) ? fw[15 - bi] : 1'b0;
    assign dout_a = (bi_a < 16) ? fw_a[15 - bi_a] : 1'b0;
    always @(negedge CS_N) bi <= 0;
    always @(negedge SCLK) if (!CS_N) begin
        bi <= bi + 1;
        dw <= {dw[14:0], DIN};
    end
    always @(negedge cs_a) bi_a <= 0;
    always @(negedge sclk_a) if (!cs_a) bi_a <= bi_a + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] ctrl(input logic [1:0] ch);
        return {4'h8, ch, 10'h010};
    endfunction

    // Runs one frame; returns in the second QUIET cycle where strobes are visible.
    task automatic run_frame(input logic [15:0] w);
        int n;
        fw = w;
        n = 0;
        while (CS_N !== 1'b0 && n < 400) begin @(negedge CLK); n++; end
        total++;
        if (CS_N !== 1'b0) begin $display("FAIL frame_start CS_N=%b exp=0", CS_N); bad++; end
        t_prev = t_start;
        t_start = cyc;
        n = 0;
        while (CS_N !== 1'b1 && n < 400) begin @(negedge CLK); n++; end
        total++;
        if (CS_N !== 1'b1) begin $display("FAIL frame_end CS_N=%b exp=1", CS_N); bad++; end
        @(negedge CLK);
    endtask

    task automatic run_frame_a(input logic [15:0] w);
        int n;
        fw_a = w;
        n = 0;
        while (cs_a !== 1'b0 && n < 400) begin @(negedge CLK); n++; end
        n = 0;
        while (cs_a !== 1'b1 && n < 400) begin @(negedge CLK); n++; end
        total++;
        if (cs_a !== 1'b1 || n >= 400) begin $display("FAIL avg_frame_timeout cs=%b", cs_a); bad++; end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if ({CS_N, SCLK, DIN, CH_VALID, FRAME_ERR, BUSY} !== 9'b110_0000_00) begin
            $display("FAIL rst_ctrl got=%b exp=110000000", {CS_N, SCLK, DIN, CH_VALID, FRAME_ERR, BUSY}); bad++;
        end
        total++;
        if (CH_DATA !== 48'h0) begin $display("FAIL rst_data got=%h exp=0", CH_DATA); bad++; end
        total++;
        if ({cs_a, sclk_a, busy_a, vld_a} !== 4'b1100) begin
            $display("FAIL rst_avg got=%b exp=1100", {cs_a, sclk_a, busy_a, vld_a}); bad++;
        end
        RSTn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_prime();
        EN = 1'b1;
        run_frame(16'h0000);
        total++;
        if (CH_VALID !== 4'b0 || FRAME_ERR !== 1'b0) begin
            $display("FAIL prime_discard vld=%b err=%b exp=0000/0", CH_VALID, FRAME_ERR); bad++;
        end
        total++;
        if (dw !== ctrl(2'd0)) begin $display("FAIL prime_din got=%h exp=%h", dw, ctrl(2'd0)); bad++; end
        run_frame(16'h1000);
        total++;
        if (CH_VALID !== 4'b0001 || FRAME_ERR !== 1'b0 || CH_DATA[11:0] !== 12'h000) begin
            $display("FAIL first_sample vld=%b err=%b d0=%h exp=0001/0/000", CH_VALID, FRAME_ERR, CH_DATA[11:0]); bad++;
        end
        total++;
        if (dw !== ctrl(2'd1)) begin $display("FAIL din_ch1 got=%h exp=%h", dw, ctrl(2'd1)); bad++; end
        total++;
        if (t_start - t_prev !== 70) begin $display("FAIL frame_period got=%0d exp=70", t_start - t_prev); bad++; end
        @(negedge CLK);
        total++;
        if (CH_VALID !== 4'b0) begin $display("FAIL strobe_width vld=%b exp=0000", CH_VALID); bad++; end
    endtask

    task automatic test_round_robin();
        run_frame(16'h2000);
        total++;
        if (CH_VALID !== 4'b0010 || CH_DATA[23:12] !== 12'h800 || dw !== ctrl(2'd2)) begin
            $display("FAIL rr_ch1 vld=%b d=%h din=%h exp=0010/800/%h", CH_VALID, CH_DATA[23:12], dw, ctrl(2'd2)); bad++;
        end
        run_frame(16'h4FFF);
        total++;
        if (CH_VALID !== 4'b0100 || CH_DATA[35:24] !== 12'hFFF || dw !== ctrl(2'd3)) begin
            $display("FAIL rr_ch2 vld=%b d=%h din=%h exp=0100/fff/%h", CH_VALID, CH_DATA[35:24], dw, ctrl(2'd3)); bad++;
        end
        run_frame(16'h7FFF);
        total++;
        if (CH_VALID !== 4'b1000 || CH_DATA[47:36] !== 12'h7FF || dw !== ctrl(2'd0)) begin
            $display("FAIL rr_ch3_wrap vld=%b d=%h din=%h exp=1000/7ff/%h", CH_VALID, CH_DATA[47:36], dw, ctrl(2'd0)); bad++;
        end
        total++;
        if (CH_DATA !== 48'h7FF_FFF_800_000) begin $display("FAIL rr_all got=%h exp=7fffff800000", CH_DATA); bad++; end
    endtask

    task automatic test_frame_err();
        logic [47:0] snap;
        run_frame(16'h0123);
        total++;
        if (CH_VALID !== 4'b0001 || CH_DATA[11:0] !== 12'h891 || dw !== ctrl(2'd1)) begin
            $display("FAIL err_pre vld=%b d=%h din=%h exp=0001/891/%h", CH_VALID, CH_DATA[11:0], dw, ctrl(2'd1)); bad++;
        end
        snap = CH_DATA;
        run_frame(16'h4000);
        total++;
        if (FRAME_ERR !== 1'b1 || CH_VALID !== 4'b0) begin
            $display("FAIL err_bad_id err=%b vld=%b exp=1/0000", FRAME_ERR, CH_VALID); bad++;
        end
        run_frame(16'hC000);
        total++;
        if (FRAME_ERR !== 1'b1 || CH_VALID !== 4'b0) begin
            $display("FAIL err_bit15 err=%b vld=%b exp=1/0000", FRAME_ERR, CH_VALID); bad++;
        end
        total++;
        if (CH_DATA !== snap) begin $display("FAIL err_hold got=%h exp=%h", CH_DATA, snap); bad++; end
        run_frame(16'h6005);
        total++;
        if (CH_VALID !== 4'b1000 || FRAME_ERR !== 1'b0 || CH_DATA[47:36] !== 12'h802) begin
            $display("FAIL err_recover3 vld=%b err=%b d=%h exp=1000/0/802", CH_VALID, FRAME_ERR, CH_DATA[47:36]); bad++;
        end
        run_frame(16'h0FFF);
        total++;
        if (CH_VALID !== 4'b0001 || CH_DATA[11:0] !== 12'hFFF) begin
            $display("FAIL err_recover0 vld=%b d=%h exp=0001/fff", CH_VALID, CH_DATA[11:0]); bad++;
        end
        run_frame(16'h3800);
        total++;
        if (CH_VALID !== 4'b0010 || CH_DATA[23:12] !== 12'h400) begin
            $display("FAIL err_recover1 vld=%b d=%h exp=0010/400", CH_VALID, CH_DATA[23:12]); bad++;
        end
    endtask

    task automatic test_en_drop();
        int n;
        bit stayed;
        fw = 16'h4000;
        n = 0;
        while (CS_N !== 1'b0 && n < 400) begin @(negedge CLK); n++; end
        repeat (20) @(negedge CLK);
        total++;
        if (CS_N !== 1'b0 || BUSY !== 1'b1) begin $display("FAIL en_drop_mid cs=%b busy=%b exp=0/1", CS_N, BUSY); bad++; end
        EN = 1'b0;
        n = 0;
        while (CS_N !== 1'b1 && n < 400) begin @(negedge CLK); n++; end
        total++;
        if (bi !== 16) begin $display("FAIL en_drop_falls got=%0d exp=16", bi); bad++; end
        @(negedge CLK);
        total++;
        if (CH_VALID !== 4'b0100 || CH_DATA[35:24] !== 12'h800) begin
            $display("FAIL en_drop_eval vld=%b d=%h exp=0100/800", CH_VALID, CH_DATA[35:24]); bad++;
        end
        repeat (4) @(negedge CLK);
        total++;
        if (BUSY !== 1'b0 || CS_N !== 1'b1) begin $display("FAIL en_drop_idle busy=%b cs=%b exp=0/1", BUSY, CS_N); bad++; end
        stayed = 1'b1;
        repeat (100) begin
            @(negedge CLK);
            if (CS_N !== 1'b1 || BUSY !== 1'b0) stayed = 1'b0;
        end
        total++;
        if (!stayed) begin $display("FAIL en_drop_stay got=0 exp=1"); bad++; end
        EN = 1'b1;
        run_frame(16'h0000);
        total++;
        if (CH_VALID !== 4'b0 || FRAME_ERR !== 1'b0 || dw !== ctrl(2'd0)) begin
            $display("FAIL reen_prime vld=%b err=%b din=%h exp=0000/0/%h", CH_VALID, FRAME_ERR, dw, ctrl(2'd0)); bad++;
        end
        run_frame(16'h0800);
        total++;
        if (CH_VALID !== 4'b0001 || CH_DATA[11:0] !== 12'hC00 || dw !== ctrl(2'd1)) begin
            $display("FAIL reen_sample vld=%b d=%h din=%h exp=0001/c00/%h", CH_VALID, CH_DATA[11:0], dw, ctrl(2'd1)); bad++;
        end
    endtask

    task automatic test_avg();
        logic [15:0] seq [5];
        seq = '{16'h0064, 16'h0064, 16'h0066, 16'h0068, 16'h006A};
        en_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_frame_a(seq[i]);
            total++;
            if (i < 4) begin
                if (vld_a !== 1'b0 || err_a !== 1'b0) begin
                    $display("FAIL avg_nostrobe%0d vld=%b err=%b exp=0/0", i, vld_a, err_a); bad++;
                end
            end else if (vld_a !== 1'b1 || err_a !== 1'b0 || data_a !== 12'h833) begin
                $display("FAIL avg_mean vld=%b err=%b d=%h exp=1/0/833", vld_a, err_a, data_a); bad++;
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        fw = 16'h2AAA;
        n = 0;
        while (CS_N !== 1'b0 && n < 400) begin @(negedge CLK); n++; end
        n = 0;
        while (bi != 7 && n < 400) begin @(negedge CLK); n++; end
        RSTn = 1'b0;
        #1;
        total++;
        if ({CS_N, SCLK, DIN, CH_VALID, FRAME_ERR, BUSY} !== 9'b110_0000_00 || CH_DATA !== 48'h0) begin
            $display("FAIL rst_mid ctrl=%b data=%h exp=110000000/0", {CS_N, SCLK, DIN, CH_VALID, FRAME_ERR, BUSY}, CH_DATA); bad++;
        end
        @(negedge CLK);
        RSTn = 1'b1;
        run_frame(16'h0000);
        total++;
        if (CH_VALID !== 4'b0 || FRAME_ERR !== 1'b0 || dw !== ctrl(2'd0)) begin
            $display("FAIL rst_mid_prime vld=%b err=%b din=%h exp=0000/0/%h", CH_VALID, FRAME_ERR, dw, ctrl(2'd0)); bad++;
        end
        run_frame(16'h1FFF);
        total++;
        if (CH_VALID !== 4'b0001 || CH_DATA !== 48'h0000_0000_07FF) begin
            $display("FAIL rst_mid_restart vld=%b d=%h exp=0001/7ff", CH_VALID, CH_DATA); bad++;
        end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_round_robin();
        test_frame_err();
        test_en_drop();
        test_avg();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_scan_avg.md
Name: adc_scan_avg

Overview:
- Parametrised successor to the single-purpose AD7324 reader.
- Runs the SPI master itself and scans N_CH channels round-robin.
- Validates each returned 16-bit frame, converts two's-complement to offset binary, optionally averages 2^AVG_LOG2 samples per channel, and presents per-channel M-bit results with valid strobes to the compensator/LCD path.

Parameters:
- N_CH, 4, channels scanned (1..4), channel 0 first.
- M, 12, result width (1..13); top M bits of the 13-bit offset-binary value.
- CLK_DIV, 2, CLK cycles per SCLK half-period (>=1).
- QUIET_CYC, 4, CLK cycles CS_N held high between frames (>=2).
- AVG_LOG2, 0, log2 of samples averaged per output (0..4).
- CTRL_BASE, 16'h8010, control word sent on DIN; bits [11:10] replaced by the addressed channel.

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  asynchronous active-low reset.
- EN  in  1  scan enable (level).
- DOUT  in  1  ADC serial data out.
- CS_N  out  1  ADC chip select, active low.
- SCLK  out  1  ADC serial clock, idles high.
- DIN  out  1  ADC serial data in (control word).
- CH_DATA  out  N_CH*M  result of channel i in [i*M +: M].
- CH_VALID  out  N_CH  one-cycle strobe per channel on result update.
- FRAME_ERR  out  1  one-cycle strobe on rejected frame.
- BUSY  out  1  high whenever not in IDLE.

Behaviour:
- Reset (async, RSTn=0): CS_N=1, SCLK=1, DIN=0, CH_DATA=0, CH_VALID=0, FRAME_ERR=0, BUSY=0. Also clears state, accumulators, sample counters, channel pointer and prime flag. Reset mid-frame aborts the frame immediately.
- States: IDLE -> SETUP -> SHIFT -> QUIET -> (SETUP | IDLE).
- IDLE: exit to SETUP when EN=1. Pointer = 0, prime flag set, accumulators cleared.
- SETUP: CS_N=0, SCLK=1 for CLK_DIV cycles. DIN = bit15 of the control word for the pointer channel.
- SHIFT: 16 SCLK periods of 2*CLK_DIV cycles each, low half first.
  - On each SCLK fall, DOUT is captured into the shift register, MSB first.
  - DIN advances to the next control bit on each SCLK rise.
  - After the 16th rise, CS_N=1 and the state goes to QUIET.
- QUIET: CS_N=1 for QUIET_CYC cycles. The frame is evaluated in the first QUIET cycle; outputs update at the end of that cycle, so CH_VALID/FRAME_ERR are high in the 2nd QUIET cycle. At the end of QUIET: SETUP if EN=1, else IDLE. EN deassertion never truncates a frame.
- Sequencing:
  - The pointer increments mod N_CH at each QUIET entry.
  - The ADC returns the channel addressed in the previous frame, so the expected ID is the previous pointer value.
  - The first frame after IDLE is discarded (prime flag cleared, no strobes, no error).
- Frame check:
  - Frame bits [15]=0, [14:13]=ID, [12:0]=sample.
  - bit15=1 or ID != expected: FRAME_ERR pulse; sample dropped; that channel's accumulator/count unchanged.
  - ID >= N_CH is always an error.
- Conversion: off13 = sample with bit12 inverted (adds 4096). -4096 -> 0; 0 -> 4096; 4095 -> 8191.
- Averaging: per-channel accumulator of width 13+AVG_LOG2 plus a sample counter.
  - On the 2^AVG_LOG2-th good sample: mean = (acc+off13) >> AVG_LOG2 (truncating).
  - CH_DATA slice = mean[12 -: M]; CH_VALID[i] pulses; accumulator and count reset to 0.
  - AVG_LOG2=0: every good sample updates directly.
- CH_DATA slices hold between updates. At most one CH_VALID bit is high per cycle.
- Frame period = CLK_DIV + 32*CLK_DIV + QUIET_CYC cycles (70 at defaults).

Test Plan:
- Reset, EN=1, model returns ID=prev channel: first frame gives no strobe. Second frame has DOUT=16'h1000 (ID0, -4096) -> CH_VALID[0] pulse, CH_DATA[11:0]=12'h000. Frame period is 70 CLKs.
- Round-robin: ch1 sample 0 -> 12'h800; ch2 sample +4095 -> 12'hFFF; ch3 sample -1 -> 12'h7FF. Pointer wraps 3->0, and DIN bits[11:10] follow 0,1,2,3,0.
- AVG_LOG2=2: ch0 samples 100,102,104,106 -> single CH_VALID[0] on the 4th, CH_DATA=12'h833. No strobe on samples 1-3.
- Model returns ID=2 when 1 is expected, then a frame with bit15=1 -> two FRAME_ERR pulses, CH_DATA unchanged. Next correct ch1 frame updates normally.
- EN dropped mid-SHIFT -> frame completes, then IDLE with CS_N=1, BUSY=0. Re-enable -> priming frame discarded again.
- RSTn low at SCLK fall #7 -> CS_N=1, SCLK=1, all outputs 0 immediately. After release with EN=1, clean restart from ch0.
